// File: rtl/thread_scheduler_la_if.sv
// Thread scheduler CPU / thread_state bus.
// master : scheduler side (drives read addresses, RELOAD, thread_num, status)
// slave  : environment side (thread_state RAM data, NEXT_THREAD, entry_pt_switch)
interface thread_scheduler_la_if #(
   parameter int unsigned N_THREADS = 16,
   parameter int unsigned LOOKAHEAD = 2,
   parameter int unsigned TS_WIDTH  = 2
);
   localparam int unsigned TW = $clog2(N_THREADS);

   logic                          entry_pt_switch;
   logic [LOOKAHEAD*TW-1:0]       ts_rd_num;
   logic [LOOKAHEAD*TS_WIDTH-1:0] ts_rd;
   logic                          NEXT_THREAD;
   logic                          RELOAD;
   logic [TW-1:0]                 thread_num;
   logic                          thread_init;
   logic                          suspended;

   modport master (
      input  entry_pt_switch, ts_rd, NEXT_THREAD,
      output ts_rd_num, RELOAD, thread_num, thread_init, suspended
   );

   modport slave (
      output entry_pt_switch, ts_rd, NEXT_THREAD,
      input  ts_rd_num, RELOAD, thread_num, thread_init, suspended
   );
endinterface

// File: rtl/thread_scheduler_la.sv
// Lookahead thread selector: scans LOOKAHEAD thread_state entries per cycle
// and switches to the nearest WR_RDY thread, pulsing RELOAD on every switch.
// Ports:
//   CLK, RESET_N        clock, asynchronous active-low reset
//   bus (master)        thread_state read ports + CPU handshake
//   stat_clr            synchronous statistics clear
//   stat_susp_cycles    saturating count of suspended (non-init) cycles
//   stat_switches       wrapping count of RELOAD cycles
module thread_scheduler_la #(
   parameter int unsigned          N_THREADS = 16,
   parameter int unsigned          LOOKAHEAD = 2,
   parameter int unsigned          TS_WIDTH  = 2,
   parameter logic [TS_WIDTH-1:0]  TS_WR_RDY = TS_WIDTH'(2),
   parameter int unsigned          TS_DELAY  = 2
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   thread_scheduler_la_if.master  bus,
   input  logic                   stat_clr,
   output logic [31:0]            stat_susp_cycles,
   output logic [31:0]            stat_switches
);
   localparam int unsigned TW = $clog2(N_THREADS);
   localparam int unsigned AW = $clog2(TS_DELAY + 1);
   localparam logic [TW:0] N_W  = (TW+1)'(N_THREADS);
   localparam logic [TW:0] LA_W = (TW+1)'(LOOKAHEAD);

   typedef enum logic [1:0] {ST_INIT = 2'd0, ST_SUSP = 2'd1, ST_RUN = 2'd2} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] thread_num_q, thread_num_d;
   logic [TW-1:0] ahead_q, ahead_d;
   logic [AW-1:0] susp_age_q, susp_age_d;
   logic          thread_init_q, thread_init_d;
   logic          suspended_q, suspended_d;
   logic [31:0]   susp_cnt_q, susp_cnt_d;
   logic [31:0]   sw_cnt_q, sw_cnt_d;
   logic          hit_c, reload_c;
   logic [TW-1:0] sel_c;

   // (a + b) mod N; a < N and b <= N, so one conditional subtract suffices
   function automatic logic [TW-1:0] mod_add(input logic [TW-1:0] a, input logic [TW:0] b);
      logic [TW:0] s;
      s = (TW+1)'(a) + b;
      if (s >= N_W) s = s - N_W;
      return TW'(s);
   endfunction

   // Window scan; iterating downward leaves the nearest eligible candidate in sel_c
   always_comb begin : scan_p
      logic [TW-1:0] cand;
      cand          = '0;
      hit_c         = 1'b0;
      sel_c         = '0;
      bus.ts_rd_num = '0;
      for (int k = LOOKAHEAD - 1; k >= 0; k--) begin
         cand = mod_add(ahead_q, (TW+1)'(k));
         bus.ts_rd_num[k*TW +: TW] = cand;
         // the current thread is only reselectable once it has been idle long enough
         if ((bus.ts_rd[k*TS_WIDTH +: TS_WIDTH] == TS_WR_RDY) &&
             !((cand == thread_num_q) &&
               ((state_q == ST_RUN) || (susp_age_q < AW'(TS_DELAY))))) begin
            hit_c = 1'b1;
            sel_c = cand;
         end
      end
   end

   // Next-state, RELOAD and statistics
   always_comb begin
      state_d       = state_q;
      thread_num_d  = thread_num_q;
      ahead_d       = ahead_q;
      susp_age_d    = susp_age_q;
      thread_init_d = thread_init_q;
      suspended_d   = suspended_q;
      susp_cnt_d    = susp_cnt_q;
      sw_cnt_d      = sw_cnt_q;
      reload_c      = ~thread_init_q & ~bus.entry_pt_switch & hit_c &
                      ((state_q == ST_SUSP) | bus.NEXT_THREAD);

      if (bus.entry_pt_switch) begin
         state_d       = ST_INIT;
         thread_num_d  = '0;
         ahead_d       = TW'(1);
         susp_age_d    = '0;
         thread_init_d = 1'b1;
         suspended_d   = 1'b1;
      end else begin
         unique case (state_q)
            ST_INIT: begin
               if (thread_num_q == TW'(N_THREADS - 1)) begin
                  state_d       = ST_SUSP;
                  thread_num_d  = '0;
                  ahead_d       = TW'(1);
                  susp_age_d    = '0;
                  thread_init_d = 1'b0;
               end else begin
                  thread_num_d = thread_num_q + TW'(1);
               end
            end
            ST_SUSP: begin
               if (hit_c) begin
                  state_d      = ST_RUN;
                  thread_num_d = sel_c;
                  ahead_d      = mod_add(sel_c, (TW+1)'(1));
                  suspended_d  = 1'b0;
               end else begin
                  ahead_d = mod_add(ahead_q, LA_W);
                  if (susp_age_q < AW'(TS_DELAY)) susp_age_d = susp_age_q + AW'(1);
               end
            end
            ST_RUN: begin
               if (bus.NEXT_THREAD && hit_c) begin
                  thread_num_d = sel_c;
                  ahead_d      = mod_add(sel_c, (TW+1)'(1));
               end else if (bus.NEXT_THREAD) begin
                  state_d     = ST_SUSP;
                  susp_age_d  = '0;
                  suspended_d = 1'b1;
                  ahead_d     = mod_add(ahead_q, LA_W);
               end else if (!hit_c) begin
                  ahead_d = mod_add(ahead_q, LA_W);
               end
            end
            default: begin
               state_d = ST_INIT;
            end
         endcase
      end

      if (stat_clr) susp_cnt_d = '0;
      else if ((state_q == ST_SUSP) && (susp_cnt_q != 32'hFFFF_FFFF)) susp_cnt_d = susp_cnt_q + 32'd1;

      if (stat_clr) sw_cnt_d = '0;
      else if (reload_c) sw_cnt_d = sw_cnt_q + 32'd1;
   end

   // State register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q       <= ST_INIT;
         thread_num_q  <= '0;
         ahead_q       <= TW'(1);
         susp_age_q    <= '0;
         thread_init_q <= 1'b1;
         suspended_q   <= 1'b1;
         susp_cnt_q    <= '0;
         sw_cnt_q      <= '0;
      end else begin
         state_q       <= state_d;
         thread_num_q  <= thread_num_d;
         ahead_q       <= ahead_d;
         susp_age_q    <= susp_age_d;
         thread_init_q <= thread_init_d;
         suspended_q   <= suspended_d;
         susp_cnt_q    <= susp_cnt_d;
         sw_cnt_q      <= sw_cnt_d;
      end
   end

   assign bus.RELOAD       = reload_c;
   assign bus.thread_num   = thread_num_q;
   assign bus.thread_init  = thread_init_q;
   assign bus.suspended    = suspended_q;
   assign stat_susp_cycles = susp_cnt_q;
   assign stat_switches    = sw_cnt_q;
endmodule

// File: tb/tb_thread_scheduler_la.sv
// Randomized scoreboard bench for thread_scheduler_la (N=12, LOOKAHEAD=3, TS_DELAY=2).
// The driver models the thread_state RAM, applies random control inputs and pushes
// the expected outputs of each cycle; the monitor pops and compares at the falling edge.
module tb_thread_scheduler_la;
   localparam int N    = 12;
   localparam int L    = 3;
   localparam int D    = 2;
   localparam int TW   = 4;
   localparam int NCYC = 3000;
   localparam logic [1:0] RDY = 2'd2;

   typedef struct {
      logic             reload;
      int               thr;
      logic             init;
      logic             susp;
      logic [L*TW-1:0]  rdnum;
      logic [31:0]      sc;
      logic [31:0]      sw;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stat_clr = 1'b0;
   logic [31:0] susp_cnt, sw_cnt;
   logic [1:0]  mem [N];
   exp_t        q[$];
   int          total = 0;
   int          bad = 0;

   // reference model state
   int          st;        // 0 = init, 1 = suspended, 2 = running
   int          m_thr, m_ahead, m_age;
   logic [31:0] m_sc, m_sw;

   thread_scheduler_la_if #(.N_THREADS(N), .LOOKAHEAD(L), .TS_WIDTH(2)) bus();

   thread_scheduler_la #(
      .N_THREADS(N), .LOOKAHEAD(L), .TS_WIDTH(2), .TS_WR_RDY(RDY), .TS_DELAY(D)
   ) dut (
      .CLK(clk),
      .RESET_N(rst_n),
      .bus(bus),
      .stat_clr(stat_clr),
      .stat_susp_cycles(susp_cnt),
      .stat_switches(sw_cnt)
   );

   always #5 clk = ~clk;

   // thread_state RAM read ports, same-cycle data
   always_comb begin
      bus.ts_rd = '0;
      for (int k = 0; k < L; k++) begin
         int idx;
         idx = int'(bus.ts_rd_num[k*TW +: TW]);
         bus.ts_rd[k*2 +: 2] = (idx < N) ? mem[idx] : 2'd0;
      end
   end

   function automatic void model_reset();
      st = 0; m_thr = 0; m_ahead = 1 % N; m_age = 0; m_sc = '0; m_sw = '0;
   endfunction

   function automatic logic [1:0] rand_ts(input int pct);
      int r;
      if ($urandom_range(99) < pct) return RDY;
      r = $urandom_range(2);
      return (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : 2'd3;
   endfunction

   // Expected outputs for this cycle, then (if adv) the model's state after the edge
   task automatic model_cycle(input logic eps, input logic nt, input logic clr, input bit adv);
      int   c, sel;
      bit   hit;
      exp_t e;
      hit = 0; sel = 0;
      for (int k = L - 1; k >= 0; k--) begin
         c = (m_ahead + k) % N;
         if (mem[c] == RDY && !(c == m_thr && (st == 2 || m_age < D))) begin
            hit = 1; sel = c;
         end
      end
      e.reload = (st != 0) && !eps && hit && (st == 1 || nt);
      e.thr    = m_thr;
      e.init   = (st == 0);
      e.susp   = (st != 2);
      e.sc     = m_sc;
      e.sw     = m_sw;
      e.rdnum  = '0;
      for (int k = 0; k < L; k++) e.rdnum[k*TW +: TW] = TW'((m_ahead + k) % N);
      q.push_back(e);
      if (!adv) return;

      if (clr) m_sc = '0;
      else if (st == 1 && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (clr) m_sw = '0;
      else if (e.reload) m_sw = m_sw + 1;

      if (eps) begin
         st = 0; m_thr = 0; m_ahead = 1; m_age = 0;
      end else if (st == 0) begin
         if (m_thr == N - 1) begin st = 1; m_thr = 0; m_ahead = 1; m_age = 0; end
         else m_thr = m_thr + 1;
      end else if (st == 1) begin
         if (hit) begin st = 2; m_thr = sel; m_ahead = (sel + 1) % N; end
         else begin
            m_ahead = (m_ahead + L) % N;
            m_age   = (m_age + 1 > D) ? D : m_age + 1;
         end
      end else begin
         if (nt && hit) begin m_thr = sel; m_ahead = (sel + 1) % N; end
         else if (nt) begin st = 1; m_age = 0; m_ahead = (m_ahead + L) % N; end
         else if (!hit) m_ahead = (m_ahead + L) % N;
      end
   endtask

   task automatic chk(input string nm, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0d expected=%0d", nm, $time, got, exp);
      end
   endtask

   // Monitor: compares what the DUT presents against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("RELOAD",           longint'(bus.RELOAD),      longint'(e.reload));
            chk("thread_num",       longint'(bus.thread_num),  longint'(e.thr));
            chk("thread_init",      longint'(bus.thread_init), longint'(e.init));
            chk("suspended",        longint'(bus.suspended),   longint'(e.susp));
            chk("ts_rd_num",        longint'(bus.ts_rd_num),   longint'(e.rdnum));
            chk("stat_susp_cycles", longint'(susp_cnt),        longint'(e.sc));
            chk("stat_switches",    longint'(sw_cnt),          longint'(e.sw));
         end
      end
   end

   // Driver + reference model
   initial begin
      int   ph, pct, ntp;
      logic eps, nt, clr;
      bit   rst_pulse;
      bus.entry_pt_switch = 1'b0;
      bus.NEXT_THREAD     = 1'b0;
      foreach (mem[i]) mem[i] = 2'd0;
      model_reset();

      // held in reset: reset values must be visible
      repeat (2) begin
         @(posedge clk); #1;
         model_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      end

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk); #1;
         ph  = (cyc / 250) % 4;
         pct = (ph == 1) ? 10 : (ph == 2) ? 90 : 40;
         ntp = (ph == 2) ? 100 : (ph == 3) ? 50 : 30;

         if (cyc % 250 == 0) begin
            if (ph == 0) begin
               foreach (mem[i]) mem[i] = 2'd0;
               mem[$urandom_range(N - 1)] = RDY;
            end else begin
               foreach (mem[i]) mem[i] = rand_ts(pct);
            end
         end else if (ph != 0 && $urandom_range(3) == 0) begin
            mem[$urandom_range(N - 1)] = rand_ts(pct);
         end

         rst_pulse = (cyc > 50) && ($urandom_range(399) == 0);
         rst_n     = !rst_pulse;
         eps       = ($urandom_range(119) == 0);
         nt        = ($urandom_range(99) < ntp);
         clr       = ($urandom_range(39) == 0);
         bus.entry_pt_switch = eps;
         bus.NEXT_THREAD     = nt;
         stat_clr            = clr;

         if (rst_pulse) begin
            model_reset();
            model_cycle(eps, nt, clr, 1'b0);
         end else begin
            model_cycle(eps, nt, clr, 1'b1);
         end
      end

      @(negedge clk); #1;
      chk("queue_drain", longint'(q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
